fifo_in_sequencer: RTL
======================

Name: fifo_in_sequencer

Overview:
- Shot-level controller for the FIFO input stage of the lidar acquisition chain.
- Arms on a software acquisition request and qualifies each external laser trigger.
- Issues one single-cycle start pulse per shot to the FIFO input block, then tracks that block's data_valid window to detect frame completion.
- Counts completed shots up to PULSE_NUM and reports done, timeout, frame-length error and missed-trigger status to the accumulator/host logic.

Parameters:
- PULSE_NUM, 16: shots per accumulation, range 1..65535.
- FRAME_LEN, 200: expected number of data_valid-high cycles per shot.
- TIMEOUT, 4096: maximum cycles from the start pulse to the end of the data_valid window.
- TRIG_HOLDOFF, 8: cycles after a frame ends during which triggers are ignored before re-arming.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset).
- acq_start, input, 1: single-cycle request to begin an accumulation.
- acq_abort, input, 1: single-cycle request to return to idle.
- trig_in, input, 1: laser trigger, already synchronous to clk; its rising edge is used.
- fifo_data_valid, input, 1: data_valid output of the FIFO input block.
- clr_err, input, 1: clears the sticky error flags.
- fifo_start, output, 1: single-cycle start pulse to the FIFO input block.
- busy, output, 1: high in every state except IDLE.
- acc_done, output, 1: single-cycle pulse when PULSE_NUM frames are complete.
- pulse_cnt, output, 16: completed frames in the current accumulation.
- timeout_err, output, 1: sticky; a frame exceeded TIMEOUT.
- len_err, output, 1: sticky; a frame's valid-cycle count was not equal to FRAME_LEN.
- trig_miss, output, 8: saturating count of triggers that arrived while not in ARM.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; internal counters 0; trig_in edge register 0.
- Registered outputs: all outputs come from registers. fifo_start is high in the cycle after the transition into START, for exactly 1 cycle.
- Trigger edge: trig_rise = trig_in & ~trig_d, where trig_d is trig_in delayed by 1 cycle.
- State IDLE:
  - acq_start=1: pulse_cnt←0, go to ARM.
  - Otherwise stay in IDLE.
- State ARM:
  - trig_rise: go to START.
- State START (1 cycle): assert fifo_start; clear the timeout counter and the valid counter; go to WAIT_VALID.
- State WAIT_VALID:
  - Timeout counter +1 per cycle.
  - fifo_data_valid=1: valid counter←1, go to STREAM.
- State STREAM:
  - Timeout counter +1 per cycle.
  - fifo_data_valid=1: valid counter +1.
  - fifo_data_valid=0 (frame end):
    - pulse_cnt+1.
    - If valid counter ≠ FRAME_LEN, set len_err.
    - If new pulse_cnt == PULSE_NUM, go to DONE; else go to HOLDOFF.
- Timeout: if the timeout counter reaches TIMEOUT-1 in WAIT_VALID or STREAM, set timeout_err and go to IDLE. pulse_cnt is kept (not cleared) and acc_done is not pulsed.
- State HOLDOFF: count TRIG_HOLDOFF cycles, then go to ARM.
- State DONE: acc_done=1 for 1 cycle, then go to IDLE. pulse_cnt holds PULSE_NUM until the next acq_start.
- trig_miss: on trig_rise in any state other than ARM or IDLE, increment, saturating at 255. It is cleared by acq_start accepted in IDLE.
- Priority:
  - acq_abort (in any state) has highest priority: go to IDLE next cycle, no acc_done, pulse_cnt kept.
  - acq_start outside IDLE is ignored.
- Sticky flags: clr_err clears timeout_err and len_err. If a set condition and clr_err occur in the same cycle, the set wins.
- Arithmetic: counters are 16-bit unsigned. The valid counter saturates at 65535, which is then reported as len_err.
- Reset mid-frame: returns immediately to the reset state. The FIFO input block is reset by the same reset net.

Test Plan:
- PULSE_NUM=3, FRAME_LEN=200: acq_start, then 3 triggers 1000 cycles apart, with the FIFO model giving 200 valid cycles each → 3 fifo_start pulses, pulse_cnt 1,2,3, one acc_done, then IDLE with busy=0.
- Model gives 199 valid cycles on shot 2 → len_err=1 after shot 2 ends, sequence still completes. Then clr_err → len_err=0.
- Model never raises valid → timeout_err=1 exactly TIMEOUT cycles after fifo_start, state IDLE, acc_done stays 0.
- Extra trigger 50 cycles after a start pulse, plus one in HOLDOFF → trig_miss=2 and no extra fifo_start. The trigger after HOLDOFF is accepted.
- acq_abort during STREAM with pulse_cnt=1 → IDLE next cycle, pulse_cnt=1, no acc_done. A new acq_start resets pulse_cnt to 0.
- rst=0 asserted asynchronously in WAIT_VALID → all outputs 0 immediately. Release, then acq_start → normal sequence.

Source files
------------

// File: rtl/fifo_in_sequencer.sv
// Shot-level sequencer for the lidar FIFO input stage: arms on acq_start, qualifies
// laser triggers, pulses fifo_start and supervises each data_valid frame.
module fifo_in_sequencer #(
  parameter int PULSE_NUM    = 16,
  parameter int FRAME_LEN    = 200,
  parameter int TIMEOUT      = 4096,
  parameter int TRIG_HOLDOFF = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acq_start,
  input  logic        acq_abort,
  input  logic        trig_in,
  input  logic        fifo_data_valid,
  input  logic        clr_err,
  output logic        fifo_start,
  output logic        busy,
  output logic        acc_done,
  output logic [15:0] pulse_cnt,
  output logic        timeout_err,
  output logic        len_err,
  output logic [7:0]  trig_miss
);

  typedef enum logic [2:0] {
    IDLE, ARM, START, WAIT_VALID, STREAM, HOLDOFF, DONE
  } state_t;

  localparam logic [15:0] PULSE_TARGET = 16'(PULSE_NUM);
  localparam logic [15:0] FRAME_TARGET = 16'(FRAME_LEN);
  // Compared against the pre-increment value so the error lands TIMEOUT cycles after fifo_start
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 2);
  localparam logic [15:0] HOLDOFF_LAST = 16'(TRIG_HOLDOFF - 1);

  state_t      state_reg, state_next;
  logic        trig_d_reg;
  logic        trig_rise;
  logic        timeout_hit;
  logic        frame_end;
  logic [15:0] tcnt_reg, tcnt_next;
  logic [15:0] vcnt_reg, vcnt_next;
  logic [15:0] pulse_cnt_reg, pulse_cnt_next;
  logic [7:0]  trig_miss_reg, trig_miss_next;
  logic [1:0]  err_reg, err_set;
  logic        fifo_start_reg, busy_reg, acc_done_reg;

  assign trig_rise   = trig_in & ~trig_d_reg;
  assign timeout_hit = ((state_reg == WAIT_VALID) || (state_reg == STREAM)) &&
                       (tcnt_reg == TIMEOUT_LAST);
  assign frame_end   = (state_reg == STREAM) && !fifo_data_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (acq_abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:       if (acq_start) state_next = ARM;
        ARM:        if (trig_rise) state_next = START;
        START:      state_next = WAIT_VALID;
        WAIT_VALID: begin
          if (timeout_hit)          state_next = IDLE;
          else if (fifo_data_valid) state_next = STREAM;
        end
        STREAM: begin
          if (timeout_hit)    state_next = IDLE;
          else if (frame_end) state_next = ((pulse_cnt_reg + 16'd1) == PULSE_TARGET) ? DONE : HOLDOFF;
        end
        HOLDOFF:    if (tcnt_reg == HOLDOFF_LAST) state_next = ARM;
        DONE:       state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // tcnt doubles as the holdoff counter: it is cleared on frame end and reused in HOLDOFF
  always_comb begin
    tcnt_next      = tcnt_reg;
    vcnt_next      = vcnt_reg;
    pulse_cnt_next = pulse_cnt_reg;
    trig_miss_next = trig_miss_reg;
    err_set        = 2'b00;
    if (trig_rise && (state_reg != ARM) && (state_reg != IDLE) && (trig_miss_reg != 8'hFF))
      trig_miss_next = trig_miss_reg + 8'd1;
    case (state_reg)
      IDLE: begin
        if (acq_start && !acq_abort) begin
          pulse_cnt_next = 16'd0;
          trig_miss_next = 8'd0;
        end
      end
      START: begin
        tcnt_next = 16'd0;
        vcnt_next = 16'd0;
      end
      WAIT_VALID: begin
        tcnt_next = tcnt_reg + 16'd1;
        if (fifo_data_valid) vcnt_next = 16'd1;
      end
      STREAM: begin
        tcnt_next = tcnt_reg + 16'd1;
        if (fifo_data_valid) begin
          if (vcnt_reg != 16'hFFFF) vcnt_next = vcnt_reg + 16'd1;
        end else if (!timeout_hit && !acq_abort) begin
          tcnt_next      = 16'd0;
          pulse_cnt_next = pulse_cnt_reg + 16'd1;
          err_set[1]     = (vcnt_reg != FRAME_TARGET);
        end
      end
      HOLDOFF: tcnt_next = tcnt_reg + 16'd1;
      default: ;
    endcase
    err_set[0] = timeout_hit && !acq_abort;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_d_reg     <= 1'b0;
      tcnt_reg       <= 16'd0;
      vcnt_reg       <= 16'd0;
      pulse_cnt_reg  <= 16'd0;
      trig_miss_reg  <= 8'd0;
      err_reg        <= 2'b00;
      fifo_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      acc_done_reg   <= 1'b0;
    end else begin
      trig_d_reg     <= trig_in;
      tcnt_reg       <= tcnt_next;
      vcnt_reg       <= vcnt_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      trig_miss_reg  <= trig_miss_next;
      fifo_start_reg <= (state_next == START);
      busy_reg       <= (state_next != IDLE);
      acc_done_reg   <= (state_next == DONE);
      // A set in the same cycle as clr_err takes precedence
      for (int i = 0; i < 2; i++) begin
        if (err_set[i])   err_reg[i] <= 1'b1;
        else if (clr_err) err_reg[i] <= 1'b0;
      end
    end
  end

  assign fifo_start  = fifo_start_reg;
  assign busy        = busy_reg;
  assign acc_done    = acc_done_reg;
  assign pulse_cnt   = pulse_cnt_reg;
  assign trig_miss   = trig_miss_reg;
  assign timeout_err = err_reg[0];
  assign len_err     = err_reg[1];

endmodule
